prog_feeder: RTL and testbench

- Upstream stage of the 8-bit CPU core.
- Buffers a short program of 6-bit instruction words (opcode[1:0], regA[1:0], regB[1:0]), loaded through a valid/ready write port.
- In run mode, replays the word addressed by the core's program counter.
- instr_out drives the core's instruction pins io_in[7:2]; pc_in is taken from the core's output byte while it is in PC-display mode.

---
 rtl/prog_feeder_if.sv | 30 +++
 rtl/prog_feeder.sv | 123 ++++++++++++
 tb/tb_prog_feeder.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/prog_feeder_if.sv
// Load/replay bus between the program source, the CPU core and prog_feeder.
// master = program source / core side, slave = prog_feeder.
interface prog_feeder_if #(
    parameter int AW = 4,
    parameter int IW = 6
);
    logic          load_start;
    logic          wr_valid;
    logic [IW-1:0] wr_data;
    logic          wr_ready;
    logic          load_done;
    logic          run_start;
    logic [7:0]    pc_in;
    logic          pc_valid;
    logic [IW-1:0] instr_out;
    logic          instr_valid;
    logic [AW:0]   prog_len;
    logic [1:0]    state;
    logic          overflow;

    modport master (
        output load_start, wr_valid, wr_data, load_done, run_start, pc_in, pc_valid,
        input  wr_ready, instr_out, instr_valid, prog_len, state, overflow
    );

    modport slave (
        input  load_start, wr_valid, wr_data, load_done, run_start, pc_in, pc_valid,
        output wr_ready, instr_out, instr_valid, prog_len, state, overflow
    );
endinterface

// File: rtl/prog_feeder.sv
// Program buffer feeding 6-bit instruction words to the 8-bit CPU core by program counter.
// Optional breakpoint halt enabled by defining HIDDENCPU_BREAKPOINT_EN.
//
// state | meaning
// IDLE  | program (possibly empty) held, waiting for load_start/run_start
// LOAD  | accepting words through wr_valid/wr_ready
// RUN   | replaying mem[pc_in] one cycle after each valid pc_in
// HALT  | pc ran past the program (or breakpoint), waiting for restart
module prog_feeder #(
    parameter int            DEPTH    = 16,
    parameter int            AW       = $clog2(DEPTH),
    parameter int            IW       = 6,
    parameter logic [IW-1:0] NOP_WORD = '0
) (
    input  logic        clk,
    input  logic        rst,
`ifdef HIDDENCPU_BREAKPOINT_EN
    input  logic        bp_en,
    input  logic [7:0]  bp_addr,
`endif
    prog_feeder_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;
    localparam logic [1:0] HALT = 2'd3;

    logic [IW-1:0] mem [DEPTH];
    logic [1:0]    state_q;
    logic [AW:0]   wr_ptr;
    logic [AW:0]   prog_len_q;
    logic [IW-1:0] instr_q;
    logic          instr_valid_q;
    logic          overflow_q;

    logic          wr_ready;
    logic          wr_accept;
    logic [7:0]    len_ext;
    logic          pc_in_range;
    logic          bp_hit;

    assign wr_ready    = (state_q == LOAD) && (wr_ptr < (AW+1)'(DEPTH));
    assign wr_accept   = wr_ready && bus.wr_valid;
    // full 8-bit compare so an out-of-range pc never aliases into the buffer
    assign len_ext     = 8'(prog_len_q);
    assign pc_in_range = bus.pc_in < len_ext;

`ifdef HIDDENCPU_BREAKPOINT_EN
    assign bp_hit = bp_en && (bus.pc_in == bp_addr);
`else
    assign bp_hit = 1'b0;
`endif

    // buffer storage carries no reset; prog_len=0 hides stale contents
    always_ff @(posedge clk) begin
        if (!rst && wr_accept && !bus.load_start) begin
            mem[wr_ptr[AW-1:0]] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            wr_ptr        <= '0;
            prog_len_q    <= '0;
            instr_q       <= NOP_WORD;
            instr_valid_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            instr_q       <= NOP_WORD;
            instr_valid_q <= 1'b0;
            if (bus.load_start) begin
                state_q    <= LOAD;
                wr_ptr     <= '0;
                prog_len_q <= '0;
                overflow_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.run_start && (prog_len_q != '0)) begin
                            state_q <= RUN;
                        end
                    end
                    LOAD: begin
                        if (wr_accept) begin
                            wr_ptr <= wr_ptr + 1'b1;
                        end
                        if (bus.wr_valid && !wr_ready) begin
                            overflow_q <= 1'b1;
                        end
                        if (bus.load_done) begin
                            prog_len_q <= wr_ptr + (AW+1)'(wr_accept);
                            state_q    <= IDLE;
                        end
                    end
                    RUN: begin
                        if (bus.pc_valid) begin
                            if (bp_hit || !pc_in_range) begin
                                state_q <= HALT;
                            end else begin
                                instr_q       <= mem[bus.pc_in[AW-1:0]];
                                instr_valid_q <= 1'b1;
                            end
                        end
                    end
                    HALT: begin
                        if (bus.run_start) begin
                            state_q <= RUN;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.wr_ready    = wr_ready;
    assign bus.instr_out   = instr_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.prog_len    = prog_len_q;
    assign bus.state       = state_q;
    assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_prog_feeder.sv
// Randomized self-checking bench for prog_feeder against a queue-based program model.
module tb_prog_feeder;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int IW    = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bp_en = 1'b0;
    logic [7:0] bp_addr = 8'd0;

    prog_feeder_if #(.AW(AW), .IW(IW)) bus ();

    prog_feeder #(.DEPTH(DEPTH), .AW(AW), .IW(IW)) dut (
        .clk     (clk),
        .rst     (rst),
`ifdef HIDDENCPU_BREAKPOINT_EN
        .bp_en   (bp_en),
        .bp_addr (bp_addr),
`endif
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int model[$];
    int src[$];
    bit m_ovf = 1'b0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag, input int exp_state);
        chk({tag, "_state"}, 32'(bus.state), exp_state);
        chk({tag, "_instr"}, 32'(bus.instr_out), 0);
        chk({tag, "_ivalid"}, 32'(bus.instr_valid), 0);
    endtask

    // load src into the buffer; done_last closes the load on the last write's cycle
    task automatic load_prog(input bit done_last);
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        model.delete();
        m_ovf = 1'b0;
        chk_quiet("load_entry", 1);
        foreach (src[i]) begin
            bus.wr_valid  = 1'b1;
            bus.wr_data   = 6'(src[i]);
            bus.load_done = done_last && (i == src.size() - 1);
            chk("wr_ready", 32'(bus.wr_ready), (model.size() < DEPTH) ? 1 : 0);
            if (model.size() < DEPTH) model.push_back(src[i] & 63);
            else m_ovf = 1'b1;
            tick();
        end
        bus.wr_valid = 1'b0;
        if (!(done_last && src.size() > 0)) begin
            bus.load_done = 1'b1;
            tick();
        end
        bus.load_done = 1'b0;
        chk_quiet("load_exit", 0);
        chk("prog_len", 32'(bus.prog_len), model.size());
        chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    endtask

    task automatic start_run(input bit from_halt);
        bus.run_start = 1'b1;
        tick();
        bus.run_start = 1'b0;
        chk_quiet("run_start", (from_halt || model.size() > 0) ? 2 : 0);
    endtask

    task automatic run_pc(input int pc, input bit v, output bit halted);
        int  e_ins;
        bit  e_v;
        bit  bp_on;
        bus.pc_in    = 8'(pc);
        bus.pc_valid = v;
        tick();
        bus.pc_valid = 1'b0;
`ifdef HIDDENCPU_BREAKPOINT_EN
        bp_on = bp_en && (pc == int'(bp_addr));
`else
        bp_on = 1'b0;
`endif
        e_ins  = 0;
        e_v    = 1'b0;
        halted = 1'b0;
        if (v) begin
            if (bp_on || pc >= model.size()) halted = 1'b1;
            else begin
                e_ins = model[pc];
                e_v   = 1'b1;
            end
        end
        chk("fetch_instr", 32'(bus.instr_out), e_ins);
        chk("fetch_valid", 32'(bus.instr_valid), 32'(e_v));
        chk("fetch_state", 32'(bus.state), halted ? 3 : 2);
    endtask

    task automatic do_reset_check();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model.delete();
        m_ovf = 1'b0;
        chk_quiet("reset", 0);
        chk("reset_len", 32'(bus.prog_len), 0);
        chk("reset_ovf", 32'(bus.overflow), 0);
        chk("reset_wr_ready", 32'(bus.wr_ready), 0);
    endtask

    initial begin
        bit h;
        bit last_valid;
        int len;
        bus.load_start = 1'b0;
        bus.wr_valid   = 1'b0;
        bus.wr_data    = '0;
        bus.load_done  = 1'b0;
        bus.run_start  = 1'b0;
        bus.pc_in      = '0;
        bus.pc_valid   = 1'b0;
        rst = 1'b1;
        tick();
        do_reset_check();

        // load and replay
        src = '{6'h05, 6'h1A, 6'h2F};
        load_prog(1'b0);
        start_run(1'b0);
        run_pc(0, 1'b1, h);
        run_pc(1, 1'b1, h);
        run_pc(2, 1'b1, h);
        run_pc(1, 1'b0, h);
        run_pc(3, 1'b1, h);
        chk("end_halt", 32'(h), 1);
        start_run(1'b1);
        run_pc(1, 1'b1, h);
        run_pc(200, 1'b1, h);
        chk("pc200_halt", 32'(h), 1);

        // load_start beats run_start in HALT; then an empty load refuses to run
        bus.load_start = 1'b1;
        bus.run_start  = 1'b1;
        tick();
        bus.load_start = 1'b0;
        bus.run_start  = 1'b0;
        chk("halt_both_state", 32'(bus.state), 1);
        bus.load_done = 1'b1;
        tick();
        bus.load_done = 1'b0;
        model.delete();
        chk("empty_len", 32'(bus.prog_len), 0);
        start_run(1'b0);

        // overflow: 17 writes into 16 entries
        src.delete();
        for (int i = 0; i < 17; i++) src.push_back(i);
        load_prog(1'b0);
        start_run(1'b0);
        run_pc(15, 1'b1, h);
        run_pc(16, 1'b1, h);

        // load_done together with the 2nd write
        src = '{6'h11, 6'h22};
        load_prog(1'b1);
        start_run(1'b0);
        run_pc(1, 1'b1, h);

        // reset mid-run with a valid instruction out
        run_pc(0, 1'b1, h);
        chk("pre_reset_valid", 32'(bus.instr_valid), 1);
        do_reset_check();

`ifdef HIDDENCPU_BREAKPOINT_EN
        src = '{6'h05, 6'h1A, 6'h2F};
        load_prog(1'b0);
        bp_en   = 1'b1;
        bp_addr = 8'd1;
        start_run(1'b0);
        run_pc(0, 1'b1, h);
        run_pc(1, 1'b1, h);
        chk("bp_halt", 32'(h), 1);
        bp_en = 1'b0;
`endif

        for (int it = 0; it < 30; it++) begin
            len = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, DEPTH + 2);
            src.delete();
            for (int i = 0; i < len; i++) src.push_back($urandom_range(0, 63));
            load_prog(1'($urandom_range(0, 1)));
`ifdef HIDDENCPU_BREAKPOINT_EN
            bp_en   = ($urandom_range(0, 2) == 0);
            bp_addr = 8'($urandom_range(0, model.size()));
`endif
            start_run(1'b0);
            if (model.size() == 0) continue;
            last_valid = 1'b0;
            for (int k = 0; k < 12; k++) begin
                int r;
                int pc;
                bit v;
                r  = $urandom_range(0, 9);
                if (r < 7) pc = $urandom_range(0, model.size() - 1);
                else if (r == 7) pc = $urandom_range(0, 255);
                else pc = model.size() + $urandom_range(0, 1);
                v = ($urandom_range(0, 4) != 0);
                run_pc(pc, v, h);
                last_valid = bus.instr_valid;
                if (h) begin
                    if ($urandom_range(0, 1) == 0) break;
                    start_run(1'b1);
                end else if (last_valid && (it % 7 == 3)) begin
                    do_reset_check();
                    break;
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
